mem_stage: RTL
==============

Name: mem_stage

Overview:
- Pipeline stage directly downstream of the 16-bit ALU.
- Captures the ALU result and zero flag with their control bits, and resolves beq-style branches.
- Performs data-memory loads and stores over a req/gnt/rvalid handshake.
- Presents one retired instruction per wb_valid pulse to the register-file writeback.
- Stalls the execute stage via ex_ready while a memory access is outstanding.

Parameters:
- DATA_W, 16, datapath and memory word width; matches the ALU result width.
- REG_ADDR_W, 3, destination register index width.

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute stage presents an instruction.
- ex_ready  out  1  stage can accept; high only in IDLE.
- ex_alu_result  in  DATA_W  ALU result; memory word address for loads and stores.
- ex_zero  in  1  ALU zero flag.
- ex_store_data  in  DATA_W  store data (rt value).
- ex_rd  in  REG_ADDR_W  destination register.
- ex_reg_write  in  1  instruction writes the register file.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- ex_branch  in  1  conditional branch (taken when ex_zero=1).
- ex_branch_target  in  DATA_W  precomputed branch target.
- dmem_req  out  1  memory request; held until granted.
- dmem_we  out  1  1 = write.
- dmem_addr  out  DATA_W  word address.
- dmem_wdata  out  DATA_W  write data.
- dmem_gnt  in  1  request accepted this cycle.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  DATA_W  read data.
- wb_valid  out  1  one-cycle pulse per retired instruction.
- wb_reg_write  out  1  write enable qualified by wb_valid.
- wb_rd  out  REG_ADDR_W  destination register.
- wb_data  out  DATA_W  load data or ALU result.
- pc_src  out  1  one-cycle pulse: branch taken.
- branch_target  out  DATA_W  valid when pc_src=1.

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs 0 except ex_ready, which is 1.
  - Reset asserted mid-access drops dmem_req immediately; an in-flight rvalid after reset release is ignored.
- FSM states IDLE, REQ, WAIT.
- Accept condition: ex_valid && ex_ready. The instruction fields are latched into an internal register on acceptance.
- Non-memory op accepted in cycle N:
  - Stays in IDLE.
  - wb_valid=1 in N+1 with wb_data=ALU result and wb_reg_write=ex_reg_write.
  - Throughput is 1 per cycle.
- Branch op:
  - With ex_zero=1, pc_src=1 and branch_target are registered and appear in N+1 for exactly one cycle.
  - wb_valid also pulses in N+1, with wb_reg_write forced to 0.
  - With ex_zero=0 there is no pc_src; wb_valid still pulses.
- Memory op accepted in N:
  - Go to REQ; dmem_req=1 from N+1, with addr, we and wdata stable until gnt.
  - Store: on the gnt cycle G, return to IDLE; wb_valid in G+1 with wb_reg_write=0.
  - Load: on gnt, go to WAIT. On rvalid in cycle R, return to IDLE; wb_valid in R+1 with wb_data=dmem_rdata and wb_reg_write=ex_reg_write.
  - Load with gnt and rvalid in the same cycle: skip WAIT and return directly to IDLE, treated as rvalid.
  - dmem_req deasserts the cycle after gnt.
- ex_mem_read and ex_mem_write both set: the store takes priority and the read is ignored.
- ex_ready=0 in REQ and WAIT; ex_ready returns to 1 the cycle after leaving. There is no back-to-back memory issue.
- rvalid outside WAIT (or outside REQ with gnt) is ignored.
- wb_valid, pc_src: single-cycle pulses, never held.
- Address: word address equal to ex_alu_result unchanged (no shift, no wrap logic); 16'hFFFF is passed as-is.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W and REG_ADDR_W constants.
  - mem_state_t enum (IDLE, REQ, WAIT).
  - A packed ex_mem_t struct (result, zero, store_data, rd, control bits).
- Single module; no sub-module is needed. The latched ex_mem_t register and the FSM are in the same file.

Test Plan:
- ALU op: result 16'h1234, rd=3, reg_write=1 accepted in cycle 5 -> wb_valid=1 in cycle 6, wb_data=16'h1234, wb_rd=3, ex_ready high throughout.
- Branch taken: ex_branch=1, ex_zero=1, target 16'h0040 -> pc_src=1 for exactly one cycle with branch_target=16'h0040, wb_reg_write=0. Repeat with ex_zero=0 -> pc_src stays 0.
- Store: addr 16'h0010, data 16'hBEEF, gnt delayed 3 cycles -> dmem_req/we/addr/wdata held stable 3 cycles, ex_ready=0, then wb_valid one cycle after gnt with wb_reg_write=0.
- Load: addr 16'h0020, gnt after 1 cycle, rvalid 2 cycles later with 16'hCAFE -> wb_data=16'hCAFE, wb_rd correct, wb_valid in the cycle after rvalid. Also cover the same-cycle gnt+rvalid case.
- Reset mid-load: assert rst_n=0 while in WAIT -> dmem_req=0 and ex_ready=1 immediately; a late rvalid after release produces no wb_valid.
- Back-to-back: ALU, load, ALU with ex_valid held high -> the second ALU op is accepted only after the load retires; exactly 3 wb_valid pulses, in order.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the memory stage.
//   DATA_W / REG_ADDR_W : datapath and register-index widths
//   mem_state_t         : memory-access FSM states
//   ex_mem_t            : instruction fields latched from the execute stage
package cpu_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic [DATA_W-1:0]     result;        // ALU result; overwritten by load data on completion
    logic                  zero;
    logic [DATA_W-1:0]     store_data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
    logic [DATA_W-1:0]     branch_target;
  } ex_mem_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus.
//   master (the stage) : req, we, addr, wdata out; gnt, rvalid, rdata in
//   slave  (memory)    : the reverse
// req is held with stable we/addr/wdata until gnt; rvalid/rdata return read data.
interface mem_stage_if #(
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input  gnt, rvalid, rdata);
  modport slave  (input  req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage.sv
// Memory stage sitting behind the ALU.
// Latches one instruction from execute, resolves beq-style branches, performs
// loads/stores over the dmem req/gnt/rvalid bus and retires one instruction per
// wb_valid pulse toward register-file writeback.
//   clk, rst_n        : clock, async active-low reset
//   ex_*              : instruction from execute; ex_ready high only in IDLE
//   dmem              : data-memory bus (master side)
//   wb_*              : writeback (wb_reg_write qualified by wb_valid)
//   pc_src            : one-cycle taken-branch pulse, branch_target valid with it
// Widths must match cpu_pkg, since the latched record uses the package struct.
module mem_stage #(
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [DATA_W-1:0]     ex_alu_result,
  input  logic                  ex_zero,
  input  logic [DATA_W-1:0]     ex_store_data,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_branch,
  input  logic [DATA_W-1:0]     ex_branch_target,
  mem_stage_if.master           dmem,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  pc_src,
  output logic [DATA_W-1:0]     branch_target
);
  import cpu_pkg::*;

  mem_state_t state, state_nxt;
  ex_mem_t    q;
  logic       accept, ex_is_mem, q_is_mem;
  logic       wb_fire, load_done;

  assign ex_ready  = (state == IDLE);
  assign accept    = ex_valid && ex_ready;
  assign ex_is_mem = ex_mem_read | ex_mem_write;
  assign q_is_mem  = q.mem_read | q.mem_write;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and retire decode. A store wins over a simultaneous read flag,
  // so q.mem_write alone selects the store path.
  always_comb begin
    state_nxt = state;
    wb_fire   = 1'b0;
    load_done = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        if (ex_is_mem) state_nxt = REQ;
        else           wb_fire   = 1'b1;
      end
      REQ: if (dmem.gnt) begin
        if (q.mem_write) begin
          state_nxt = IDLE;
          wb_fire   = 1'b1;
        end else if (dmem.rvalid) begin
          // gnt and rvalid together: the load completes without visiting WAIT
          state_nxt = IDLE;
          wb_fire   = 1'b1;
          load_done = 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: if (dmem.rvalid) begin
        state_nxt = IDLE;
        wb_fire   = 1'b1;
        load_done = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction record. Load data replaces the ALU result in place so the
  // writeback mux is just q.result; addr is no longer needed once data returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (accept) begin
      q <= '{result:        ex_alu_result,
             zero:          ex_zero,
             store_data:    ex_store_data,
             rd:            ex_rd,
             reg_write:     ex_reg_write,
             mem_read:      ex_mem_read,
             mem_write:     ex_mem_write,
             branch:        ex_branch,
             branch_target: ex_branch_target};
    end else if (load_done) begin
      q.result <= dmem.rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wb_valid <= 1'b0;
    else        wb_valid <= wb_fire;
  end

  // Memory bus driven straight from state so reset drops req asynchronously.
  assign dmem.req   = (state == REQ);
  assign dmem.we    = dmem.req & q.mem_write;
  assign dmem.addr  = dmem.req ? q.result : '0;
  assign dmem.wdata = dmem.we  ? q.store_data : '0;

  // Writeback / branch outputs all derive from the record plus the wb pulse.
  assign wb_data       = q.result;
  assign wb_rd         = q.rd;
  assign wb_reg_write  = wb_valid & q.reg_write & ~q.branch & ~q.mem_write;
  assign pc_src        = wb_valid & q.branch & q.zero & ~q_is_mem;
  assign branch_target = pc_src ? q.branch_target : '0;

endmodule
